// File: rtl/instruction_loader.sv
// instruction_loader
// Byte-stream to instruction-memory writer. Collects four bytes per word
// (first byte is the most significant), then issues a one-cycle write strobe
// at the next word address. Addresses start at 0 so instruction N lands at
// word address N, matching the program counter's fetch index.

module instruction_loader #(
  parameter int DEPTH = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_length,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_mem_write_enable,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_length;      // word count latched at start
  logic [31:0] r_address;     // word address of the word being assembled
  logic [1:0]  r_byte_count;  // bytes of the current word accepted so far
  logic [23:0] r_shift;       // the three most recent bytes of the current word
  logic [31:0] r_word;        // last fully assembled word, held for the write
  logic        r_error;

  logic        w_start_idle;
  logic        w_len_ok;
  logic        w_len_zero;
  logic        w_len_over;
  logic        w_xfer;
  logic        w_last_byte;
  logic [31:0] w_addr_inc;
  logic        w_last_word;

  assign w_start_idle = (r_state == S_IDLE) && i_start;
  assign w_len_zero   = (i_length == 32'd0);
  assign w_len_over   = (i_length > DEPTH_W);
  assign w_len_ok     = !w_len_zero && !w_len_over;
  assign w_xfer       = (r_state == S_RECV) && i_byte_valid;
  assign w_last_byte  = w_xfer && (r_byte_count == 2'd3);
  assign w_addr_inc   = r_address + 32'd1;
  assign w_last_word  = (w_addr_inc == r_length);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_len_zero) begin
            w_state_next = S_DONE;
          end else if (w_len_ok) begin
            w_state_next = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (w_last_byte) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_next = w_last_word ? S_DONE : S_RECV;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output decode; every control output is a pure function of the state.
  always_comb begin
    o_byte_ready       = 1'b0;
    o_mem_write_enable = 1'b0;
    o_busy             = 1'b0;
    o_done             = 1'b0;
    unique case (r_state)
      S_RECV: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
      S_WRITE: begin
        o_mem_write_enable = 1'b1;
        o_busy             = 1'b1;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath: length latch, byte assembly and word address.
  // The address only advances when another word follows, so after the final
  // write it stays on the last legal index instead of stepping to DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_length     <= 32'd0;
      r_address    <= 32'd0;
      r_byte_count <= 2'd0;
      r_shift      <= 24'd0;
      r_word       <= 32'd0;
    end else begin
      if (w_start_idle && w_len_ok) begin
        r_length     <= i_length;
        r_address    <= 32'd0;
        r_byte_count <= 2'd0;
      end
      if (w_xfer) begin
        r_shift      <= {r_shift[15:0], i_byte_data};
        r_byte_count <= r_byte_count + 2'd1;
        if (r_byte_count == 2'd3) begin
          r_word <= {r_shift, i_byte_data};
        end
      end
      if ((r_state == S_WRITE) && !w_last_word) begin
        r_address <= w_addr_inc;
      end
    end
  end

  // Sticky length error, re-evaluated on every start seen in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_error <= 1'b0;
    end else if (w_start_idle) begin
      r_error <= w_len_over;
    end
  end

  assign o_mem_address    = r_address;
  assign o_mem_write_data = r_word;
  assign o_error          = r_error;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS instruction words. Writes each word into the word-addressed instruction memory at consecutive addresses starting at 0, so the program counter reader later fetches instruction N at address N. Sits between the host/boot byte source and the instruction memory write port; the processor is held off while `busy` is high.

## Interface

- `DEPTH`, 32, number of instruction words in the memory; highest legal address is DEPTH-1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a load; sampled only in IDLE.
- `length` input 32: number of words to load; sampled with `start`.
- `byte_valid` input 1: `byte_data` is valid this cycle.
- `byte_data` input 8: stream byte; first byte of each word is bits [31:24].
- `byte_ready` output 1: loader accepts a byte this cycle.
- `mem_write_enable` output 1: one-cycle write strobe to instruction memory.
- `mem_address` output 32: word index (program counter units, not bytes).
- `mem_write_data` output 32: assembled instruction word.
- `busy` output 1: high in RECV and WRITE.
- `done` output 1: one-cycle pulse at load completion.
- `error` output 1: sticky length error; cleared by reset or by the next accepted `start`.

## Operation

- States: IDLE, RECV, WRITE, DONE.
- **IDLE**
  - `byte_ready` = 0.
  - On `start` with 1 <= `length` <= DEPTH: latch `length`, clear `error`, set address = 0 and byte count = 0, go to RECV.
  - On `start` with `length` == 0: clear `error`, go to DONE. No writes occur.
  - On `start` with `length` > DEPTH: set `error` = 1, stay in IDLE. No writes and no `done` pulse.
- **RECV**
  - `byte_ready` = 1.
  - A byte transfers when `byte_valid` && `byte_ready`: word <= {word[23:0], `byte_data`}, byte count + 1.
  - After the 4th transfer (count wraps 3 -> 0), go to WRITE.
  - `byte_valid` low means no transfer and state is held; gaps of any length are legal.
- **WRITE**
  - `mem_write_enable` = 1 for exactly one cycle, with `mem_address` = current address and `mem_write_data` = assembled word.
  - `byte_ready` = 0.
  - Next cycle: address + 1. If address + 1 == latched length, go to DONE; otherwise go to RECV.
- **DONE**
  - `done` = 1 for one cycle, then go to IDLE.
- `start` is ignored outside IDLE; the latched length is not disturbed.
- Bytes offered while `byte_ready` = 0 are not consumed. The source must hold them.
- Address arithmetic is 32-bit; the address never exceeds DEPTH-1 because length is bounded.

## Timing

- Reset values: state IDLE; `byte_ready`, `mem_write_enable`, `busy`, `done`, `error` = 0; `mem_address` = 0; `mem_write_data` = 0; byte count = 0.
- `mem_address` and `mem_write_data` are registered and stable outside WRITE. The memory must qualify them with `mem_write_enable`.
- Sequence with `byte_valid` held high, `start` sampled at edge 0:
  - Cycles 1-4: RECV, bytes accepted.
  - Cycle 5: WRITE.
  - Minimum 5 cycles per word.
  - For N words, the last write is in cycle 5N, `done` is in cycle 5N+1, and the loader is in IDLE in cycle 5N+2.
- `length` == 0: `done` in cycle 1.
- Reset asserted mid-load:
  - Next edge returns to reset values.
  - The partial word is discarded and no write is issued.
  - Memory locations already written keep their data.
- Reset has priority over `start` in the same cycle.

## Test plan

1. **Two-word load.** Reset, then `start` with `length` = 2. Stream bytes 20 08 00 05 20 09 00 0A with `byte_valid` held high. Required:
   - Write at address 0 of 0x20080005 in cycle 5.
   - Write at address 1 of 0x2009000A in cycle 10.
   - `done` in cycle 11.
   - `busy` low from cycle 11.
2. **Stalled source.** Same stream as scenario 1, with `byte_valid` dropped for 3 cycles between every byte. Required: identical write data and addresses, exactly 2 write strobes, and `done` only after the second write.
3. **Full depth.** `length` = 32 with word k = 0x0000_0000 + k. Required: 32 writes, addresses 0..31, data equal to address, `done` once.
4. **Length boundaries.**
   - `length` = 0: `done` in cycle 1 and no write.
   - `length` = 33: `error` = 1, no `done`, no write, `busy` stays 0.
   - A following valid `start` clears `error`.
5. **Reset mid-word.** `length` = 2; after word 0 is written and 2 bytes of word 1 are accepted, assert `reset` for 1 cycle. Required: no further write, all outputs at reset values. A new 1-word load of 8C0A0004 then writes 0x8C0A0004 at address 0.
6. **Start while busy.** Pulse `start` with `length` = 5 during RECV of a `length` = 2 load. Required: it is ignored, exactly 2 writes occur, and `done` follows the second write.
